fb_rect_fill: RTL and testbench
===============================

// Module: fb_rect_fill
// PURPOSE
//  Hardware fill engine upstream of framebuffer_monochrome's write port.
//  Accepts a rectangle and a fill pattern, then issues one framebuffer byte write
//  (8 horizontal pixels) per covered byte cell, in row-major order, using the
//  framebuffer we / w_data_valid handshake.
//  Replaces ad-hoc per-pixel writer loops in top-level test and UI code.
// PARAMETERS
//  FB_WIDTH   128  framebuffer width in pixels; must be a multiple of 8
//  FB_HEIGHT  64   framebuffer height in pixels
// PORTS
//  clk              in   1  system clock (27 MHz)
//  rst              in   1  asynchronous, active-high reset
//  start            in   1  1-cycle request; sampled only in IDLE
//  x0, x1           in   8  left / right pixel x, inclusive; bits [2:0] ignored (byte granular)
//  y0, y1           in   8  top / bottom row, inclusive
//  pattern          in   2  0 clear 00h; 1 set FFh; 2 checker (AAh even y, 55h odd y); 3 hstripe (FFh even y, 00h odd y)
//  abort            in   1  level; stop after the in-flight write completes
//  busy             out  1  high from the cycle after an accepted start until the return to IDLE
//  done             out  1  1-cycle pulse: rectangle fully written
//  err              out  1  1-cycle pulse: start rejected (bad coordinates)
//  fb_busy          in   1  framebuffer busy
//  fb_we            out  1  framebuffer write enable
//  fb_w_xpos        out  8  write x; always a multiple of 8
//  fb_w_ypos        out  8  write y
//  fb_din           out  8  write data, MSB = leftmost pixel
//  fb_w_data_valid  in   1  framebuffer write acknowledge
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, fb_we = 0; fb_w_xpos, fb_w_ypos, fb_din = 0.
//   Reset is asynchronous: fb_we drops immediately even mid-handshake.
//  Format: done, err and fb_* are registered outputs.
//  IDLE: on start, validate. Reject if any of x0>x1, y0>y1, x1>=FB_WIDTH, y1>=FB_HEIGHT:
//   err=1 for one cycle, no write, stay IDLE.
//   Otherwise latch all inputs; cur_x={x0[7:3],3'b0}; cur_y=y0; busy=1; go WAIT_FB.
//  WAIT_FB: if abort, go FINISH without done. Else, when fb_busy==0,
//   next cycle fb_we=1 with fb_w_xpos=cur_x, fb_w_ypos=cur_y, fb_din=pattern(cur_y[0]);
//   go WRITE.
//  WRITE: hold fb_we, address and data stable until fb_w_data_valid==1.
//   In that cycle's next edge fb_we=0; go ADVANCE.
//   No timeout; abort never truncates a handshake.
//  ADVANCE (1 cycle):
//   - abort high: go FINISH, done suppressed.
//   - cur_x[7:3]==x1[7:3] and cur_y==y1: go FINISH, done asserted.
//   - cur_x[7:3]==x1[7:3]: cur_x=x0 byte; cur_y+=1.
//   - otherwise: cur_x+=8.
//   - After either increment, go WAIT_FB.
//  FINISH (1 cycle): done pulses if completed; busy=0 at the following edge; return to IDLE.
//  Arithmetic: 8-bit counters; bounds are checked at start, so no wrap is possible.
//  Write count = (x1[7:3]-x0[7:3]+1)*(y1-y0+1).
//  Minimum cost per write is 3 cycles (WAIT_FB, WRITE with same-cycle ack, ADVANCE).
//  Start while busy: ignored, with no err.
//  Inputs x0..pattern may change freely once a start is accepted.
//  Abort in IDLE has no effect.
//  Pattern changes mid-fill do not apply; the latched value is used.
//  Only one fb_we assertion per cell.
//  fb_we never rises while fb_busy is high in the preceding cycle.
// TESTING
//  1. Full clear: x0=0,x1=127,y0=0,y1=63,pat=0, fb ack 2 cycles after we
//     -> exactly 1024 writes, din=00h, row-major order (0,0),(8,0)..(120,63); one done pulse; busy low after.
//  2. Single cell: x0=x1=13, y0=y1=5, pat=1 -> one write xpos=8, ypos=5, din=FFh; done.
//  3. Checker: x0=0,x1=15,y0=2,y1=3,pat=2 -> writes (0,2,AAh),(8,2,AAh),(0,3,55h),(8,3,55h) in that order.
//  4. Rejects: x0=16,x1=8; then y1=64 -> each gives a single err pulse, no fb_we, busy stays 0.
//     A start while busy -> ignored, no err.
//  5. Backpressure: fb_busy high for 100 cycles -> fb_we stays 0.
//     Release fb_busy and hold ack low 50 cycles -> we, xpos, ypos, din stable throughout.
//  6. Abort during WRITE -> fb_we held until ack, then IDLE with no done.
//     Async rst mid-fill -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/fb_rect_fill_if.sv
// Command and framebuffer write-port signals of the rectangle fill engine.
// The engine is the slave: it receives commands and drives the framebuffer write port.
interface fb_rect_fill_if;
    // Command side: start is a one-cycle request, sampled only while busy is low.
    // Write side: fb_we with fb_w_xpos/fb_w_ypos/fb_din is a valid that stays high and stable
    // until fb_w_data_valid (ready) is seen at a clock edge; the write completes at that edge.
    logic       start;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] y0;
    logic [7:0] y1;
    logic [1:0] pattern;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic       fb_busy;
    logic       fb_we;
    logic [7:0] fb_w_xpos;
    logic [7:0] fb_w_ypos;
    logic [7:0] fb_din;
    logic       fb_w_data_valid;

    modport slave (
        input  start, x0, x1, y0, y1, pattern, abort, fb_busy, fb_w_data_valid,
        output busy, done, err, fb_we, fb_w_xpos, fb_w_ypos, fb_din
    );

    modport master (
        output start, x0, x1, y0, y1, pattern, abort, fb_busy, fb_w_data_valid,
        input  busy, done, err, fb_we, fb_w_xpos, fb_w_ypos, fb_din
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: walks the covered byte cells of a rectangle in row-major order
// and issues one framebuffer byte write per cell with a fixed fill pattern.
module fb_rect_fill #(
    parameter int FB_WIDTH  = 128,
    parameter int FB_HEIGHT = 64
) (
    input  logic             clk,
    input  logic             rst,
    fb_rect_fill_if.slave    bus,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FB = 3'd1,
        WRITE   = 3'd2,
        ADVANCE = 3'd3,
        FINISH  = 3'd4
    } state_e;

    localparam logic [8:0] W_LIM = 9'(FB_WIDTH);
    localparam logic [8:0] H_LIM = 9'(FB_HEIGHT);

    state_e     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       we_q, we_d;
    logic [7:0] xpos_q, xpos_d;
    logic [7:0] ypos_q, ypos_d;
    logic [7:0] din_q, din_d;
    logic [4:0] x0b_q, x0b_d;
    logic [4:0] x1b_q, x1b_d;
    logic [7:0] y1_q, y1_d;
    logic [1:0] pat_q, pat_d;
    logic [7:0] cur_x_q, cur_x_d;
    logic [7:0] cur_y_q, cur_y_d;

    logic       bad_rect;
    logic [7:0] pat_byte;
    logic       row_end;

    assign bad_rect = (bus.x0 > bus.x1) || (bus.y0 > bus.y1) ||
                      ({1'b0, bus.x1} >= W_LIM) || ({1'b0, bus.y1} >= H_LIM);
    assign row_end  = (cur_x_q[7:3] == x1b_q);

    // Odd/even row selects the phase of the checker and stripe patterns.
    always_comb begin
        pat_byte = 8'h00;
        case (pat_q)
            2'd0: pat_byte = 8'h00;
            2'd1: pat_byte = 8'hFF;
            2'd2: pat_byte = cur_y_q[0] ? 8'h55 : 8'hAA;
            2'd3: pat_byte = cur_y_q[0] ? 8'h00 : 8'hFF;
            default: pat_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we_d    = we_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        din_d   = din_q;
        x0b_d   = x0b_q;
        x1b_d   = x1b_q;
        y1_d    = y1_q;
        pat_d   = pat_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bad_rect) begin
                        err_d = 1'b1;
                    end else begin
                        x0b_d   = bus.x0[7:3];
                        x1b_d   = bus.x1[7:3];
                        y1_d    = bus.y1;
                        pat_d   = bus.pattern;
                        cur_x_d = {bus.x0[7:3], 3'b000};
                        cur_y_d = bus.y0;
                        busy_d  = 1'b1;
                        state_d = WAIT_FB;
                    end
                end
            end
            WAIT_FB: begin
                if (bus.abort) begin
                    state_d = FINISH;
                end else if (!bus.fb_busy) begin
                    we_d    = 1'b1;
                    xpos_d  = cur_x_q;
                    ypos_d  = cur_y_q;
                    din_d   = pat_byte;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Abort is deliberately not looked at here: a started handshake always completes.
                if (bus.fb_w_data_valid) begin
                    we_d    = 1'b0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (bus.abort) begin
                    state_d = FINISH;
                end else if (row_end && (cur_y_q == y1_q)) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else if (row_end) begin
                    cur_x_d = {x0b_q, 3'b000};
                    cur_y_d = cur_y_q + 8'd1;
                    state_d = WAIT_FB;
                end else begin
                    cur_x_d = cur_x_q + 8'd8;
                    state_d = WAIT_FB;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            xpos_q  <= 8'h00;
            ypos_q  <= 8'h00;
            din_q   <= 8'h00;
            x0b_q   <= 5'd0;
            x1b_q   <= 5'd0;
            y1_q    <= 8'h00;
            pat_q   <= 2'd0;
            cur_x_q <= 8'h00;
            cur_y_q <= 8'h00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            din_q   <= din_d;
            x0b_q   <= x0b_d;
            x1b_q   <= x1b_d;
            y1_q    <= y1_d;
            pat_q   <= pat_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.fb_we     = we_q;
    assign bus.fb_w_xpos = xpos_q;
    assign bus.fb_w_ypos = ypos_q;
    assign bus.fb_din    = din_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: a framebuffer responder, a write monitor checked against a
// row-major cell list built from the rectangle rules, and one task per scenario.
module tb_fb_rect_fill;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dut_state;

    always #5 clk = ~clk;

    fb_rect_fill_if bus();

    fb_rect_fill #(.FB_WIDTH(128), .FB_HEIGHT(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dut_state)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_w;
    logic [23:0] cur_w = 24'h0;

    int ack_lat  = 0;
    bit bp_force = 1'b0;
    bit bp_rand  = 1'b0;

    int we_rise_cnt = 0;
    int we_hi_cnt   = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int busy_cnt    = 0;
    logic prev_we     = 1'b0;
    logic prev_fbbusy = 1'b0;

    // Framebuffer model: acks ack_lat cycles after fb_we rises; drives fb_busy.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.fb_busy         = 1'b0;
        bus.fb_w_data_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.fb_we) begin
                wcnt++;
                bus.fb_w_data_valid = (wcnt > ack_lat);
            end else begin
                wcnt = 0;
                bus.fb_w_data_valid = 1'b0;
            end
            bus.fb_busy = bp_force || (bp_rand && ($urandom_range(0, 3) == 0));
        end
    end

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.fb_we && !prev_we) begin
            we_rise_cnt++;
            checks++;
            if (prev_fbbusy) begin
                errors++;
                $display("FAIL we_after_fb_busy: fb_we rose at %0t with fb_busy=1 the cycle before", $time);
            end
            cur_w = {bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got x=%0d y=%0d din=%02h, expected no write",
                         cur_w[23:16], cur_w[15:8], cur_w[7:0]);
            end else begin
                exp_w = exp_q.pop_front();
                if (cur_w !== exp_w) begin
                    errors++;
                    $display("FAIL write_cell: got x=%0d y=%0d din=%02h, expected x=%0d y=%0d din=%02h",
                             cur_w[23:16], cur_w[15:8], cur_w[7:0], exp_w[23:16], exp_w[15:8], exp_w[7:0]);
                end
            end
        end else if (bus.fb_we && prev_we) begin
            checks++;
            if ({bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din} !== cur_w) begin
                errors++;
                $display("FAIL write_stable: got %06h, expected %06h held",
                         {bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din}, cur_w);
            end
        end
        if (bus.fb_we)  we_hi_cnt++;
        if (bus.done)   done_cnt++;
        if (bus.err)    err_cnt++;
        if (bus.busy)   busy_cnt++;
        prev_we     = bus.fb_we;
        prev_fbbusy = bus.fb_busy;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    function automatic logic [7:0] exp_byte(input int pat, input int y);
        case (pat)
            0: return 8'h00;
            1: return 8'hFF;
            2: return (y % 2 == 0) ? 8'hAA : 8'h55;
            default: return (y % 2 == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // Every byte cell the rectangle touches, row by row, left to right.
    task automatic build_exp(input int x0, input int x1, input int y0, input int y1, input int pat);
        for (int y = y0; y <= y1; y++) begin
            for (int xb = x0 / 8; xb <= x1 / 8; xb++) begin
                exp_q.push_back({8'(xb * 8), 8'(y), exp_byte(pat, y)});
            end
        end
    endtask

    task automatic clear_counts();
        we_rise_cnt = 0;
        we_hi_cnt   = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        busy_cnt    = 0;
    endtask

    // One-cycle start pulse; afterwards the inputs are scrambled since they must no longer matter.
    task automatic start_rect(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1, input logic [1:0] pat);
        @(posedge clk);
        #2;
        bus.x0 = x0;
        bus.x1 = x1;
        bus.y0 = y0;
        bus.y1 = y1;
        bus.pattern = pat;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start   = 1'b0;
        bus.x0      = 8'($urandom);
        bus.x1      = 8'($urandom);
        bus.y0      = 8'($urandom);
        bus.y1      = 8'($urandom);
        bus.pattern = 2'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, budget);
        end
        repeat (3) @(posedge clk);
        #3;
    endtask

    task automatic run_fill(input int x0, input int x1, input int y0, input int y1,
                            input int pat, input int lat, input string name);
        int n;
        ack_lat = lat;
        clear_counts();
        build_exp(x0, x1, y0, y1, pat);
        n = exp_q.size();
        start_rect(8'(x0), 8'(x1), 8'(y0), 8'(y1), 2'(pat));
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_rise: busy=%b, expected 1", name, bus.busy);
        end
        wait_idle(20000, name);
        checks++;
        if (exp_q.size() != 0 || we_rise_cnt != n) begin
            errors++;
            $display("FAIL %s_count: writes=%0d missing=%0d, expected writes=%0d missing=0",
                     name, we_rise_cnt, exp_q.size(), n);
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL %s_done: done_cycles=%0d err_cycles=%0d, expected 1 and 0", name, done_cnt, err_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.x0 = 8'h00;
        bus.x1 = 8'h00;
        bus.y0 = 8'h00;
        bus.y1 = 8'h00;
        bus.pattern = 2'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.fb_we, bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din, dut_state} !== 31'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b we=%b x=%h y=%h din=%h st=%0d, expected all 0",
                     bus.busy, bus.done, bus.err, bus.fb_we, bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din, dut_state);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic test_rejects();
        clear_counts();
        bus.abort = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        bus.abort = 1'b0;
        start_rect(8'd16, 8'd8, 8'd0, 8'd0, 2'd1);
        repeat (3) @(posedge clk);
        start_rect(8'd0, 8'd8, 8'd0, 8'd64, 2'd1);
        repeat (3) @(posedge clk);
        start_rect(8'd0, 8'd128, 8'd0, 8'd0, 2'd1);
        repeat (3) @(posedge clk);
        start_rect(8'd0, 8'd8, 8'd5, 8'd4, 2'd1);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (err_cnt != 4) begin
            errors++;
            $display("FAIL reject_err: err_cycles=%0d, expected 4", err_cnt);
        end
        checks++;
        if (we_rise_cnt != 0 || busy_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reject_quiet: writes=%0d busy_cycles=%0d done=%0d, expected 0 0 0",
                     we_rise_cnt, busy_cnt, done_cnt);
        end
    endtask

    task automatic test_busy_ignore();
        ack_lat = 3;
        clear_counts();
        build_exp(0, 31, 0, 1, 1);
        start_rect(8'd0, 8'd31, 8'd0, 8'd1, 2'd1);
        repeat (4) @(posedge clk);
        start_rect(8'd0, 8'd0, 8'd9, 8'd9, 2'd0);
        repeat (4) @(posedge clk);
        start_rect(8'd40, 8'd8, 8'd0, 8'd99, 2'd2);
        wait_idle(2000, "busy_ignore");
        checks++;
        if (exp_q.size() != 0 || we_rise_cnt != 8) begin
            errors++;
            $display("FAIL busy_ignore_count: writes=%0d missing=%0d, expected 8 and 0", we_rise_cnt, exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL busy_ignore_done: done=%0d err=%0d, expected 1 and 0", done_cnt, err_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        ack_lat = 50;
        bp_force = 1'b1;
        clear_counts();
        build_exp(16, 31, 7, 7, 3);
        start_rect(8'd16, 8'd31, 8'd7, 8'd7, 2'd3);
        repeat (100) @(negedge clk);
        checks++;
        if (we_rise_cnt != 0 || bus.fb_we !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: writes=%0d we=%b while fb_busy high, expected 0 0", we_rise_cnt, bus.fb_we);
        end
        @(posedge clk);
        #1;
        bp_force = 1'b0;
        wait_idle(1000, "backpressure");
        checks++;
        if (exp_q.size() != 0 || we_rise_cnt != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_result: writes=%0d missing=%0d done=%0d, expected 2 0 1",
                     we_rise_cnt, exp_q.size(), done_cnt);
        end
        checks++;
        if (we_hi_cnt < 100) begin
            errors++;
            $display("FAIL bp_we_held: we_cycles=%0d, expected at least 100", we_hi_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_abort_write();
        int n;
        ack_lat = 10;
        clear_counts();
        build_exp(0, 63, 0, 3, 1);
        start_rect(8'd0, 8'd63, 8'd0, 8'd3, 2'd1);
        n = 0;
        while (bus.fb_we !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        wait_idle(500, "abort_write");
        bus.abort = 1'b0;
        checks++;
        if (we_rise_cnt != 1 || exp_q.size() != 31 || we_hi_cnt < 10) begin
            errors++;
            $display("FAIL abort_write_count: writes=%0d left=%0d we_cycles=%0d, expected 1 31 >=10",
                     we_rise_cnt, exp_q.size(), we_hi_cnt);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_write_done: done=%0d, expected 0", done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_abort_wait();
        bp_force = 1'b1;
        clear_counts();
        build_exp(8, 8, 1, 1, 1);
        start_rect(8'd8, 8'd8, 8'd1, 8'd1, 2'd1);
        repeat (5) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        wait_idle(100, "abort_wait");
        bus.abort = 1'b0;
        bp_force = 1'b0;
        checks++;
        if (we_rise_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL abort_wait: writes=%0d done=%0d, expected 0 0", we_rise_cnt, done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int x0, x1, y0, y1;
        bp_rand = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x0 = $urandom_range(0, 127);
            x1 = $urandom_range(x0, 127);
            y0 = $urandom_range(0, 63);
            y1 = y0 + $urandom_range(0, 3);
            if (y1 > 63) y1 = 63;
            run_fill(x0, x1, y0, y1, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
        bp_rand = 1'b0;
    endtask

    task automatic test_async_reset();
        ack_lat = 2;
        clear_counts();
        build_exp(0, 127, 0, 7, 1);
        start_rect(8'd0, 8'd127, 8'd0, 8'd7, 2'd1);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.fb_we, bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b err=%b we=%b x=%h y=%h din=%h, expected all 0",
                     bus.busy, bus.done, bus.err, bus.fb_we, bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
    endtask

    initial begin
        test_reset();
        run_fill(0, 127, 0, 63, 0, 2, "full_clear");
        run_fill(13, 13, 5, 5, 1, 0, "single_cell");
        run_fill(0, 15, 2, 3, 2, 1, "checker");
        run_fill(8, 40, 10, 13, 3, 0, "hstripe");
        test_rejects();
        test_busy_ignore();
        test_backpressure();
        test_abort_write();
        test_abort_wait();
        test_random();
        test_async_reset();
        run_fill(120, 127, 63, 63, 2, 0, "after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
